// File: rtl/ctrl_opcode_encoder.sv
// rtl/ctrl_opcode_encoder.sv - control-vector to opcode encoder with opcode FIFO and error tracking
module ctrl_opcode_encoder #(
    parameter int DEPTH        = 4,
    parameter int ERR_CNT_W    = 8,
    parameter int ALIAS_ROTATE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_sel_reg_dst,
    input  logic                       in_alu_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_opcode,
    output logic                       err_pulse,
    output logic                       err_sticky,
    input  logic                       err_clr,
    output logic [ERR_CNT_W-1:0]       err_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [2:0]    last_q;
    logic [1:0]    alias_zero_ptr;
    logic [1:0]    alias_five_ptr;

    logic [2:0] req_key;
    logic       enc_ok;
    logic [2:0] enc_op;
    logic       hit_zero;
    logic       hit_five;
    logic       accept;
    logic       push;
    logic       pop;
    logic       err_evt;

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign push      = accept & enc_ok;
    assign err_evt   = accept & ~enc_ok;
    assign req_key   = {in_sel_reg_dst, in_alu_op};

    // When empty the head shows the most recently popped opcode rather than stale storage.
    assign out_opcode = out_valid ? mem[rd_ptr] : last_q;

    // Map the requested control vector to an opcode; alias pointers select among equivalent opcodes.
    always_comb begin
        enc_ok   = 1'b0;
        enc_op   = 3'd0;
        hit_zero = 1'b0;
        hit_five = 1'b0;
        case (req_key)
            3'b000: begin
                enc_ok   = 1'b1;
                hit_zero = 1'b1;
                enc_op   = (ALIAS_ROTATE != 0) ? {alias_zero_ptr, 1'b0} : 3'd0;
            end
            3'b110: begin
                enc_ok = 1'b1;
                enc_op = 3'd1;
            end
            3'b100: begin
                enc_ok = 1'b1;
                enc_op = 3'd3;
            end
            3'b011: begin
                enc_ok   = 1'b1;
                hit_five = 1'b1;
                enc_op   = (ALIAS_ROTATE != 0) ? (3'd5 + {1'b0, alias_five_ptr}) : 3'd5;
            end
            default: begin
                enc_ok = 1'b0;
            end
        endcase
    end

    // Opcode FIFO storage, pointers, occupancy and the last-popped holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            last_q  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_op;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Alias pointers step 0,1,2 and only on an accepted request of their own class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alias_zero_ptr <= 2'd0;
            alias_five_ptr <= 2'd0;
        end else if (ALIAS_ROTATE != 0) begin
            if (accept && hit_zero) begin
                alias_zero_ptr <= (alias_zero_ptr == 2'd2) ? 2'd0 : alias_zero_ptr + 2'd1;
            end
            if (accept && hit_five) begin
                alias_five_ptr <= (alias_five_ptr == 2'd2) ? 2'd0 : alias_five_ptr + 2'd1;
            end
        end
    end

    // Error flags: a new dropped request takes priority over a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse <= err_evt;
            if (err_evt) begin
                err_sticky <= 1'b1;
                if (err_clr) begin
                    err_count <= ERR_CNT_W'(1);
                end else if (!(&err_count)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if (err_clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_opcode_encoder.sv
// tb/tb_ctrl_opcode_encoder.sv - self-checking bench for ctrl_opcode_encoder with a queue-based model
module tb_ctrl_opcode_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_sel = 2'd0;
    logic       in_alu = 1'b0;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;

    logic       in_ready_a, out_valid_a, err_pulse_a, err_sticky_a;
    logic [2:0] out_opcode_a, level_a;
    logic [7:0] err_count_a;
    logic       in_ready_b, out_valid_b, err_pulse_b, err_sticky_b;
    logic [2:0] out_opcode_b, level_b;
    logic [1:0] err_count_b;

    int n_pass = 0;
    int n_chk  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_opcode_encoder #(.DEPTH(4), .ERR_CNT_W(8), .ALIAS_ROTATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_sel_reg_dst(in_sel), .in_alu_op(in_alu), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_opcode(out_opcode_a), .err_pulse(err_pulse_a),
        .err_sticky(err_sticky_a), .err_clr(err_clr), .err_count(err_count_a), .level(level_a)
    );

    ctrl_opcode_encoder #(.DEPTH(4), .ERR_CNT_W(2), .ALIAS_ROTATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_sel_reg_dst(in_sel), .in_alu_op(in_alu), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_opcode(out_opcode_b), .err_pulse(err_pulse_b),
        .err_sticky(err_sticky_b), .err_clr(err_clr), .err_count(err_count_b), .level(level_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: opcode table lookup, class rotation counts, queues.
    function automatic int op_of(input logic [2:0] key, input bit rot, input int n0, input int n5);
        case (key)
            3'b000:  return rot ? 2 * (n0 % 3) : 0;
            3'b110:  return 1;
            3'b100:  return 3;
            3'b011:  return rot ? 5 + (n5 % 3) : 5;
            default: return -1;
        endcase
    endfunction

    int qa[$];
    int qb[$];
    int last_a, last_b, nb0, nb5;
    int cnt_a, cnt_b;
    bit stk_a, stk_b, pls_a, pls_b;
    logic [2:0] m_key;
    int m_op_a, m_op_b;
    bit m_acc_a, m_acc_b, m_pop_a, m_pop_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete(); qb.delete();
            last_a = 0; last_b = 0; nb0 = 0; nb5 = 0;
            cnt_a = 0; cnt_b = 0; stk_a = 0; stk_b = 0; pls_a = 0; pls_b = 0;
        end else begin
            m_key   = {in_sel, in_alu};
            m_acc_a = in_valid && (qa.size() != 4);
            m_acc_b = in_valid && (qb.size() != 4);
            m_pop_a = out_ready && (qa.size() > 0);
            m_pop_b = out_ready && (qb.size() > 0);
            m_op_a  = op_of(m_key, 1'b0, 0, 0);
            m_op_b  = op_of(m_key, 1'b1, nb0, nb5);
            if (m_pop_a) last_a = qa.pop_front();
            if (m_pop_b) last_b = qb.pop_front();
            if (m_acc_a && m_op_a >= 0) qa.push_back(m_op_a);
            if (m_acc_b && m_op_b >= 0) qb.push_back(m_op_b);
            if (m_acc_b && m_key == 3'b000) nb0++;
            if (m_acc_b && m_key == 3'b011) nb5++;
            pls_a = m_acc_a && (m_op_a < 0);
            pls_b = m_acc_b && (m_op_b < 0);
            if (pls_a) begin stk_a = 1; cnt_a = err_clr ? 1 : (cnt_a < 255 ? cnt_a + 1 : 255); end
            else if (err_clr) begin stk_a = 0; cnt_a = 0; end
            if (pls_b) begin stk_b = 1; cnt_b = err_clr ? 1 : (cnt_b < 3 ? cnt_b + 1 : 3); end
            else if (err_clr) begin stk_b = 0; cnt_b = 0; end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_in_ready", in_ready_a, qa.size() != 4);
            chk("a_level", level_a, qa.size());
            chk("a_out_valid", out_valid_a, qa.size() > 0);
            chk("a_out_opcode", out_opcode_a, (qa.size() > 0) ? qa[0] : last_a);
            chk("a_err_pulse", err_pulse_a, pls_a);
            chk("a_err_sticky", err_sticky_a, stk_a);
            chk("a_err_count", err_count_a, cnt_a);
            chk("b_in_ready", in_ready_b, qb.size() != 4);
            chk("b_level", level_b, qb.size());
            chk("b_out_valid", out_valid_b, qb.size() > 0);
            chk("b_out_opcode", out_opcode_b, (qb.size() > 0) ? qb[0] : last_b);
            chk("b_err_pulse", err_pulse_b, pls_b);
            chk("b_err_sticky", err_sticky_b, stk_b);
            chk("b_err_count", err_count_b, cnt_b);
        end
    end

    task automatic send(input logic [1:0] s, input logic a);
        bit acc;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_sel = s; in_alu = a;
        for (int t = 0; t < 50 && !done; t++) begin
            acc = in_ready_a;
            @(posedge clk); #1;
            if (acc) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sel = 2'($urandom_range(0, 3));
        in_alu = 1'($urandom_range(0, 1));
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
    endtask

    int exp_b5 [8] = '{0, 5, 2, 6, 4, 7, 0, 5};

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_level", level_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_opcode", out_opcode_a, 0);
        chk("rst_in_ready", in_ready_a, 1);

        // Four encodable classes streamed with the consumer always ready.
        out_ready = 1'b1;
        send(2'b00, 1'b0); chk("t1_op0", out_opcode_a, 0); chk("t1_lvl0", level_a, 1);
        send(2'b11, 1'b0); chk("t1_op1", out_opcode_a, 1); chk("t1_lvl1", level_a, 1);
        send(2'b10, 1'b0); chk("t1_op3", out_opcode_a, 3); chk("t1_lvl3", level_a, 1);
        send(2'b01, 1'b1); chk("t1_op5", out_opcode_a, 5); chk("t1_vld5", out_valid_a, 1);
        idle(2);

        // Fill to DEPTH with the consumer stalled; fifth request waits for a pop.
        out_ready = 1'b0;
        send(2'b00, 1'b0); send(2'b11, 1'b0); send(2'b10, 1'b0); send(2'b01, 1'b1);
        chk("t2_full_level", level_a, 4);
        chk("t2_full_ready", in_ready_a, 0);
        in_sel = 2'b11; in_alu = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("t2_still_full", level_a, 4);
        out_ready = 1'b1;
        send(2'b11, 1'b0);
        chk("t2_level_after5", level_a, 3);
        chk("t2_head_after5", out_opcode_a, 3);
        idle(6);

        // Unencodable requests, then a clear colliding with a new error.
        send(2'b00, 1'b1); chk("t3_pulse1", err_pulse_a, 1);
        send(2'b11, 1'b1); chk("t3_pulse2", err_pulse_a, 1); chk("t3_count2", err_count_a, 2);
        chk("t3_sticky", err_sticky_a, 1); chk("t3_level", level_a, 0);
        idle(1); chk("t3_pulse_gone", err_pulse_a, 0);
        err_clr = 1'b1;
        send(2'b01, 1'b0);
        err_clr = 1'b0;
        chk("t3_clr_count", err_count_a, 1); chk("t3_clr_sticky", err_sticky_a, 1);
        chk("t3_clr_count_b", err_count_b, 1);
        idle(1);

        // Saturation of the narrow counter.
        send(2'b00, 1'b1); send(2'b01, 1'b0); send(2'b10, 1'b1); send(2'b11, 1'b1); send(2'b00, 1'b1);
        idle(1);
        chk("t4_sat_b", err_count_b, 3);
        chk("t4_count_a", err_count_a, 6);

        // Alias rotation per class on the rotating instance.
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 1'b0);
            chk("t5_b_zero", out_opcode_b, exp_b5[2*i]);
            chk("t5_a_zero", out_opcode_a, 0);
            send(2'b01, 1'b1);
            chk("t5_b_five", out_opcode_b, exp_b5[2*i+1]);
        end
        idle(2);

        // Asynchronous reset with opcodes buffered and errors pending.
        out_ready = 1'b0;
        send(2'b00, 1'b1);
        send(2'b00, 1'b0); send(2'b01, 1'b1); send(2'b10, 1'b0);
        idle(0);
        chk("t6_pre_level", level_a, 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid_a, 0); chk("t6_level", level_a, 0);
        chk("t6_sticky", err_sticky_a, 0); chk("t6_count", err_count_a, 0);
        chk("t6_level_b", level_b, 0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        send(2'b01, 1'b1); chk("t6_b_five_low", out_opcode_b, 5);
        send(2'b00, 1'b0); chk("t6_b_zero_low", out_opcode_b, 0);
        idle(2);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_alu    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0 || c > 760);
            err_clr   = 1'($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        err_clr = 1'b0;
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
